qpsk_dibit_packer: RTL and testbench

Downstream neighbour of the QPSK demapper. It accepts one 2-bit Gray-decoded dibit per handshake and packs consecutive dibits into W-bit words for the AXI-stream DMA/byte path. Frame ends (`din_last`) flush a zero-padded partial word with a valid-dibit count. Single output register; input backpressure is driven by the output handshake.

---
 rtl/qpsk_dibit_packer.sv | 119 +++++++++++
 tb/tb_qpsk_dibit_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_dibit_packer.sv
// qpsk_dibit_packer
// Packs 2-bit Gray-decoded dibits from the QPSK demapper into W-bit words.
// A frame end (din_last) flushes a zero-padded partial word together with
// its valid-dibit count. A single output register holds the word, and that
// register's handshake drives input backpressure.
//
// Build option:
//   QPSK_PACK_MSB_FIRST_EN  defined   -> slot k at bits [W-1-2k : W-2-2k]
//                                        (first dibit in the MSBs)
//                           undefined -> slot k at bits [2k+1 : 2k]
//                                        (first dibit in the LSBs)
module qpsk_dibit_packer #(
  parameter int W  = 32,  // output word width, even and >= 4
  parameter int CW = 5    // clog2(W/2 + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    din,
  input  logic          din_valid,
  input  logic          din_last,
  output logic          in_ready,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic          dout_last,
  output logic [CW-1:0] dout_cnt,
  input  logic          out_ready
);

  localparam int DPW = W / 2;

  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;
  logic [CW-1:0] dout_cnt_q, dout_cnt_d;

  logic [W-1:0]  acc_ins;
  logic          in_acc;
  logic          out_acc;
  logic          word_done;

  // The output register is free when it is empty or being drained this cycle.
  assign in_ready  = !dout_valid_q || out_ready;
  assign in_acc    = din_valid && in_ready;
  assign out_acc   = dout_valid_q && out_ready;
  assign word_done = in_acc && (din_last || (cnt_q == CW'(DPW - 1)));

  // Accumulator with the incoming dibit written into the current fill slot.
  // Slots above cnt are still zero, so this is also the zero-padded flush word.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    acc_ins = acc_q;
    for (int k = 0; k < DPW; k++) begin
      if (cnt_q == CW'(k)) begin
`ifdef QPSK_PACK_MSB_FIRST_EN
        acc_ins[W-2-2*k +: 2] = din;
`else
        acc_ins[2*k +: 2] = din;
`endif
      end
    end
  end

  // Next state: completing a word has priority over draining the register,
  // so a simultaneous drain and completion reloads with no bubble.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_cnt_d   = dout_cnt_q;

    if (word_done) begin
      dout_d       = acc_ins;
      dout_cnt_d   = cnt_q + CW'(1);
      dout_last_d  = din_last;
      dout_valid_d = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
    end else begin
      if (in_acc) begin
        acc_d = acc_ins;
        cnt_d = cnt_q + CW'(1);
      end
      if (out_acc) begin
        dout_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset; a reset discards any
  // buffered dibits and any word waiting in the output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_cnt_q   <= dout_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_cnt   = dout_cnt_q;

endmodule

// File: tb/tb_qpsk_dibit_packer.sv
// Self-checking bench for qpsk_dibit_packer (W=32).
// Inputs are driven 1 ns after each rising edge. A monitor samples on the
// falling edge: it checks outputs against a scoreboard queue and then
// updates a dibit-list model for the coming edge.
module tb_qpsk_dibit_packer;

  localparam int W   = 32;
  localparam int CW  = 5;
  localparam int DPW = W / 2;

  typedef struct packed {
    logic [W-1:0]  word;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    din;
  logic          din_valid;
  logic          din_last;
  logic          in_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_last;
  logic [CW-1:0] dout_cnt;
  logic          out_ready;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       sb_q[$];
  logic [1:0] m_dibits[$];

  logic [W-1:0]  last_word;
  logic [CW-1:0] last_cnt;
  logic          last_last;
  int            words_out = 0;
  logic          rand_phase = 1'b0;

  qpsk_dibit_packer #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_cnt   (dout_cnt),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Builds a zero-padded word from the dibits collected so far.
  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w;
    w = '0;
    foreach (m_dibits[i]) begin
`ifdef QPSK_PACK_MSB_FIRST_EN
      w[W-2-2*i +: 2] = m_dibits[i];
`else
      w[2*i +: 2] = m_dibits[i];
`endif
    end
    return w;
  endfunction

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_ir;
    exp_t e;
    if (!rst_n) begin
      m_dibits.delete();
      sb_q.delete();
    end else begin
      exp_ir = (sb_q.size() == 0) || out_ready;
      check("dout_valid", 64'(dout_valid), 64'(sb_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      if (sb_q.size() != 0) begin
        check("dout", 64'(dout), 64'(sb_q[0].word));
        check("dout_cnt", 64'(dout_cnt), 64'(sb_q[0].cnt));
        check("dout_last", 64'(dout_last), 64'(sb_q[0].last));
        if (out_ready) begin
          last_word = dout;
          last_cnt  = dout_cnt;
          last_last = dout_last;
          words_out++;
          void'(sb_q.pop_front());
        end
      end
      if (din_valid && exp_ir) begin
        m_dibits.push_back(din);
        if (m_dibits.size() == DPW || din_last) begin
          e.word = build_word();
          e.cnt  = CW'(m_dibits.size());
          e.last = din_last;
          sb_q.push_back(e);
          m_dibits.delete();
        end
      end
    end
  end

  // Randomised output backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_phase) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Presents one dibit and holds it until accepted (bounded wait).
  task automatic send(input logic [1:0] d, input logic l);
    int n = 0;
    din       = d;
    din_last  = l;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    din       = 2'b00;
    din_valid = 1'b0;
    din_last  = 1'b0;
    out_ready = 1'b1;
    settle(3);
    @(negedge clk);
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_dout_valid", 64'(dout_valid), 64'(0));
    check("rst_dout_last", 64'(dout_last), 64'(0));
    check("rst_dout_cnt", 64'(dout_cnt), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full word of 2'b10.
    base = words_out;
    repeat (DPW) send(2'b10, 1'b0);
    settle(3);
    check("t1_words", 64'(words_out - base), 64'(1));
    check("t1_word", 64'(last_word), 64'(32'hAAAA_AAAA));
    check("t1_cnt", 64'(last_cnt), 64'(16));
    check("t1_last", 64'(last_last), 64'(0));

    // Dibits 0,1,2,3 repeated four times.
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) send(2'(k), 1'b0);
    settle(3);
`ifdef QPSK_PACK_MSB_FIRST_EN
    check("t2_word", 64'(last_word), 64'(32'h1B1B_1B1B));
`else
    check("t2_word", 64'(last_word), 64'(32'hE4E4_E4E4));
`endif
    check("t2_cnt", 64'(last_cnt), 64'(16));

    // Short frame 3,3,3,3,1 with last, then a fresh full word.
    for (int k = 0; k < 4; k++) send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    settle(3);
`ifdef QPSK_PACK_MSB_FIRST_EN
    check("t3_word", 64'(last_word), 64'(32'hFF40_0000));
`else
    check("t3_word", 64'(last_word), 64'(32'h0000_01FF));
`endif
    check("t3_cnt", 64'(last_cnt), 64'(5));
    check("t3_last", 64'(last_last), 64'(1));
    repeat (DPW) send(2'b11, 1'b0);
    settle(3);
    check("t3_full_word", 64'(last_word), 64'(32'hFFFF_FFFF));
    check("t3_full_cnt", 64'(last_cnt), 64'(16));

    // Stall: word held with out_ready=0 while input is offered.
    out_ready = 1'b0;
    repeat (DPW) send(2'($urandom_range(0, 3)), 1'b0);
    din       = 2'b10;
    din_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_valid", 64'(dout_valid), 64'(1));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'b10, 1'b0);
    for (int k = 0; k < DPW - 1; k++) send(2'($urandom_range(0, 3)), 1'b0);
    settle(3);

    // Random traffic with random backpressure and frame ends.
    rand_phase = 1'b1;
    for (int k = 0; k < 60; k++)
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    send(2'($urandom_range(0, 3)), 1'b1);
    rand_phase = 1'b0;
    settle(2);
    out_ready = 1'b1;
    settle(3);
    check("rand_drained", 64'(sb_q.size()), 64'(0));

    // Reset mid-word discards the buffered dibits.
    base = words_out;
    repeat (7) send(2'b11, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_no_emit", 64'(words_out - base), 64'(0));
    repeat (DPW) send(2'b01, 1'b0);
    settle(3);
    check("t5_words", 64'(words_out - base), 64'(1));
    check("t5_word", 64'(last_word), 64'(32'h5555_5555));
    check("t5_cnt", 64'(last_cnt), 64'(16));

    // din_last with din_valid=0 is ignored; then a one-dibit frame.
    base = words_out;
    din       = 2'b11;
    din_last  = 1'b1;
    din_valid = 1'b0;
    settle(1);
    din_last = 1'b0;
    send(2'b10, 1'b1);
    settle(3);
    check("t6_words", 64'(words_out - base), 64'(1));
    check("t6_cnt", 64'(last_cnt), 64'(1));
    check("t6_last", 64'(last_last), 64'(1));
`ifdef QPSK_PACK_MSB_FIRST_EN
    check("t6_word", 64'(last_word), 64'(32'h8000_0000));
`else
    check("t6_word", 64'(last_word), 64'(32'h0000_0002));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
